uma_bus_arbiter: RTL and testbench

//  Arbitrates the single UMA memory port between up to N_REQ bus masters (IF, MEM, VGA, DMA...).

---
 rtl/uma_bus_arbiter_pkg.sv | 26 ++
 rtl/uma_bus_arbiter_if.sv | 34 +++
 rtl/uma_bus_arbiter_prio_encoder.sv | 32 +++
 rtl/uma_bus_arbiter.sv | 125 ++++++++++++
 tb/tb_uma_bus_arbiter.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/uma_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uma_bus_arbiter_pkg
//  Purpose  : Shared state encoding and width helper for the UMA bus arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package uma_bus_arbiter_pkg;

  // Arbiter FSM states: one idle slot between grants, busy while a grant is held
  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  // Ceiling log2, usable in constant expressions for register widths
  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uma_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : uma_bus_arbiter_if
//  Purpose  : Request/grant bundle between bus masters, UMA port and arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
interface uma_bus_arbiter_if #(
  parameter int N_REQ = 8,
  parameter int IDW   = 3
) ();

  logic [N_REQ-1:0] req;
  logic             rr_en;
  logic             mem_done;
  logic [N_REQ-1:0] gnt;
  logic [IDW-1:0]   gnt_id;
  logic             gnt_valid;
  logic             mem_start;
  logic             timeout;

  // Arbiter side
  modport slave (
    input  req, rr_en, mem_done,
    output gnt, gnt_id, gnt_valid, mem_start, timeout
  );

  // Requester / memory-port side
  modport master (
    output req, rr_en, mem_done,
    input  gnt, gnt_id, gnt_valid, mem_start, timeout
  );

endinterface
`default_nettype wire

// File: rtl/uma_bus_arbiter_prio_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : uma_prio_encoder
//  Purpose  : Combinational highest-set-bit encoder with active-low enable.
//  Revision : 1.0 - initial release
// ============================================================================
module uma_prio_encoder #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] data,
  input  logic         enable_n,
  output logic [W-1:0] result,
  output logic         result_valid
);

  // Scan upward so the highest set bit is the last one written
  always_comb begin
    result       = '0;
    result_valid = 1'b0;
    if (!enable_n) begin
      for (int i = 0; i < N; i++) begin
        if (data[i]) begin
          result       = W'(i);
          result_valid = 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uma_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : uma_bus_arbiter
//  Purpose  : Grants the single UMA memory port to one of N_REQ masters using
//             fixed (highest index) or round-robin priority; holds the grant
//             until mem_done or a HOLD_MAX-cycle timeout.
//  Revision : 1.0 - initial release
// ============================================================================
module uma_bus_arbiter
  import uma_bus_arbiter_pkg::*;
#(
  parameter int N_REQ    = 8,
  parameter int HOLD_MAX = 255,
  parameter int IDW      = 3
) (
  input  logic           clk,
  input  logic           reset,
  uma_bus_arbiter_if.slave bus
);

  localparam int c_CNT_W = (clog2(HOLD_MAX + 1) < 1) ? 1 : clog2(HOLD_MAX + 1);
  localparam logic [c_CNT_W-1:0] c_HOLD_MAX = c_CNT_W'(HOLD_MAX);

  arb_state_t         r_state, w_state_nxt;
  logic [N_REQ-1:0]   r_gnt, w_gnt_nxt;
  logic [IDW-1:0]     r_gnt_id, w_gnt_id_nxt;
  logic [IDW-1:0]     r_last_id, w_last_id_nxt;
  logic [c_CNT_W-1:0] r_hold_cnt, w_hold_cnt_nxt;
  logic               r_mem_start, w_mem_start_nxt;
  logic               r_timeout, w_timeout_nxt;

  logic [N_REQ-1:0]   w_rr_mask;
  logic [N_REQ-1:0]   w_req_masked;
  logic [IDW-1:0]     w_full_id, w_masked_id, w_win_id;
  logic               w_full_valid, w_masked_valid;

  // Round-robin favours indices below the last winner; last_id==0 gives an
  // empty mask, which falls back to plain highest-index selection
  assign w_rr_mask    = (N_REQ'(1) << r_last_id) - N_REQ'(1);
  assign w_req_masked = bus.req & w_rr_mask;

  uma_prio_encoder #(.N(N_REQ), .W(IDW)) u_enc_full (
    .data         (bus.req),
    .enable_n     (1'b0),
    .result       (w_full_id),
    .result_valid (w_full_valid)
  );

  uma_prio_encoder #(.N(N_REQ), .W(IDW)) u_enc_masked (
    .data         (w_req_masked),
    .enable_n     (~bus.rr_en),
    .result       (w_masked_id),
    .result_valid (w_masked_valid)
  );

  // Masked encoder is disabled in fixed mode, so its valid alone picks the path
  assign w_win_id = w_masked_valid ? w_masked_id : w_full_id;

  // Next-state and next-output decode
  always_comb begin
    w_state_nxt     = r_state;
    w_gnt_nxt       = r_gnt;
    w_gnt_id_nxt    = r_gnt_id;
    w_last_id_nxt   = r_last_id;
    w_hold_cnt_nxt  = r_hold_cnt;
    w_mem_start_nxt = 1'b0;
    w_timeout_nxt   = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_full_valid) begin
          w_state_nxt     = ARB_BUSY;
          w_gnt_nxt       = N_REQ'(1) << w_win_id;
          w_gnt_id_nxt    = w_win_id;
          w_hold_cnt_nxt  = '0;
          w_mem_start_nxt = 1'b1;
        end
      end
      ARB_BUSY: begin
        if (bus.mem_done || (r_hold_cnt == c_HOLD_MAX)) begin
          w_state_nxt   = ARB_IDLE;
          w_gnt_nxt     = '0;
          w_last_id_nxt = r_gnt_id;
          // A completion in the same cycle as the limit is a normal release
          w_timeout_nxt = ~bus.mem_done;
        end else begin
          // Release at c_HOLD_MAX bounds the counter, so it never wraps
          w_hold_cnt_nxt = r_hold_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ARB_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ARB_IDLE;
      r_gnt       <= '0;
      r_gnt_id    <= '0;
      r_last_id   <= '0;
      r_hold_cnt  <= '0;
      r_mem_start <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_gnt       <= w_gnt_nxt;
      r_gnt_id    <= w_gnt_id_nxt;
      r_last_id   <= w_last_id_nxt;
      r_hold_cnt  <= w_hold_cnt_nxt;
      r_mem_start <= w_mem_start_nxt;
      r_timeout   <= w_timeout_nxt;
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.gnt_id    = r_gnt_id;
  assign bus.gnt_valid = (r_state == ARB_BUSY);
  assign bus.mem_start = r_mem_start;
  assign bus.timeout   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_uma_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uma_bus_arbiter
//  Purpose  : Directed self-checking bench for uma_bus_arbiter; instance A
//             uses the default HOLD_MAX, instance B uses HOLD_MAX=4.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uma_bus_arbiter;

  logic clk;
  logic reset_a;
  logic reset_b;
  int   n_checks;
  int   n_fail;

  uma_bus_arbiter_if #(.N_REQ(8), .IDW(3)) bus_a ();
  uma_bus_arbiter_if #(.N_REQ(8), .IDW(3)) bus_b ();

  uma_bus_arbiter #(.N_REQ(8), .HOLD_MAX(255), .IDW(3)) dut_a (
    .clk   (clk),
    .reset (reset_a),
    .bus   (bus_a)
  );

  uma_bus_arbiter #(.N_REQ(8), .HOLD_MAX(4), .IDW(3)) dut_b (
    .clk   (clk),
    .reset (reset_b),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 time unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   exp_ids[6];
    logic seen;
    n_checks = 0;
    n_fail   = 0;
    reset_a  = 1'b1;
    reset_b  = 1'b1;
    bus_a.req = 8'h00; bus_a.rr_en = 1'b0; bus_a.mem_done = 1'b0;
    bus_b.req = 8'h00; bus_b.rr_en = 1'b0; bus_b.mem_done = 1'b0;
    tick();
    tick();
    check("rst_gnt",       32'(bus_a.gnt), 32'h00);
    check("rst_gnt_id",    32'(bus_a.gnt_id), 32'd0);
    check("rst_gnt_valid", 32'(bus_a.gnt_valid), 32'd0);
    check("rst_mem_start", 32'(bus_a.mem_start), 32'd0);
    check("rst_timeout",   32'(bus_a.timeout), 32'd0);
    reset_a = 1'b0;
    reset_b = 1'b0;

    // 1: idle with no requests
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen = seen | bus_a.mem_start | bus_a.gnt_valid;
    end
    check("idle_no_activity", 32'(seen), 32'd0);
    check("idle_gnt",         32'(bus_a.gnt), 32'h00);

    // 2: fixed priority, highest index wins, one idle cycle between grants
    bus_a.req = 8'hC0;
    tick();
    check("fix_gnt",       32'(bus_a.gnt), 32'h80);
    check("fix_gnt_id",    32'(bus_a.gnt_id), 32'd7);
    check("fix_mem_start", 32'(bus_a.mem_start), 32'd1);
    check("fix_valid",     32'(bus_a.gnt_valid), 32'd1);
    tick();
    check("fix_start_pulse", 32'(bus_a.mem_start), 32'd0);
    check("fix_gnt_held",    32'(bus_a.gnt), 32'h80);
    tick();
    bus_a.mem_done = 1'b1;
    tick();
    bus_a.mem_done = 1'b0;
    check("fix_rel_gnt",     32'(bus_a.gnt), 32'h00);
    check("fix_rel_valid",   32'(bus_a.gnt_valid), 32'd0);
    check("fix_rel_timeout", 32'(bus_a.timeout), 32'd0);
    tick();
    check("fix_regnt",       32'(bus_a.gnt), 32'h80);
    check("fix_regnt_start", 32'(bus_a.mem_start), 32'd1);
    bus_a.mem_done = 1'b1;
    tick();
    bus_a.mem_done = 1'b0;
    check("fix_rel2_gnt", 32'(bus_a.gnt), 32'h00);

    // 3: round-robin rotation over req=8'h31 starting after last_id=7
    bus_a.rr_en = 1'b1;
    bus_a.req   = 8'h31;
    exp_ids = '{5, 4, 0, 5, 4, 0};
    for (int i = 0; i < 6; i++) begin
      tick();
      check("rr_gnt_id", 32'(bus_a.gnt_id), 32'(exp_ids[i]));
      check("rr_gnt",    32'(bus_a.gnt), 32'h1 << exp_ids[i]);
      bus_a.mem_done = 1'b1;
      tick();
      bus_a.mem_done = 1'b0;
      check("rr_rel", 32'(bus_a.gnt_valid), 32'd0);
    end
    bus_a.req = 8'h00;

    // 4: hold timeout on instance B (HOLD_MAX=4)
    bus_b.req = 8'h01;
    tick();
    check("to_gnt", 32'(bus_b.gnt), 32'h01);
    seen = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen = seen & bus_b.gnt_valid & ~bus_b.timeout;
    end
    check("to_held_5", 32'(seen), 32'd1);
    tick();
    check("to_rel_gnt",     32'(bus_b.gnt), 32'h00);
    check("to_rel_timeout", 32'(bus_b.timeout), 32'd1);
    tick();
    check("to_regnt",       32'(bus_b.gnt), 32'h01);
    check("to_regnt_start", 32'(bus_b.mem_start), 32'd1);
    check("to_pulse_end",   32'(bus_b.timeout), 32'd0);
    for (int i = 0; i < 4; i++) tick();
    check("to_cnt4_held", 32'(bus_b.gnt), 32'h01);
    bus_b.mem_done = 1'b1;
    tick();
    bus_b.mem_done = 1'b0;
    bus_b.req      = 8'h00;
    check("to_done_gnt",     32'(bus_b.gnt), 32'h00);
    check("to_done_timeout", 32'(bus_b.timeout), 32'd0);
    tick();
    check("to_idle_valid", 32'(bus_b.gnt_valid), 32'd0);

    // 5: reset mid-BUSY after a completed grant leaves last_id=5
    bus_a.rr_en = 1'b0;
    bus_a.req   = 8'h20;
    tick();
    check("rst5_gnt", 32'(bus_a.gnt), 32'h20);
    bus_a.mem_done = 1'b1;
    tick();
    bus_a.mem_done = 1'b0;
    tick();
    tick();
    check("rst5_busy", 32'(bus_a.gnt), 32'h20);
    reset_a = 1'b1;
    tick();
    check("rst5_gnt_drop",  32'(bus_a.gnt), 32'h00);
    check("rst5_valid",     32'(bus_a.gnt_valid), 32'd0);
    check("rst5_timeout",   32'(bus_a.timeout), 32'd0);
    reset_a     = 1'b0;
    bus_a.req   = 8'h21;
    bus_a.rr_en = 1'b1;
    tick();
    check("rst5_gnt_id", 32'(bus_a.gnt_id), 32'd5);
    check("rst5_gnt_rr", 32'(bus_a.gnt), 32'h20);
    bus_a.mem_done = 1'b1;
    tick();
    bus_a.mem_done = 1'b0;
    tick();
    check("rst5_rr_next", 32'(bus_a.gnt_id), 32'd0);
    bus_a.req      = 8'h00;
    bus_a.mem_done = 1'b1;
    tick();
    bus_a.mem_done = 1'b0;

    // 6: mem_done while idle is ignored; grant holds after req drop / rr_en flip
    bus_a.rr_en    = 1'b0;
    bus_a.mem_done = 1'b1;
    tick();
    bus_a.mem_done = 1'b0;
    check("idle_done_valid",   32'(bus_a.gnt_valid), 32'd0);
    check("idle_done_timeout", 32'(bus_a.timeout), 32'd0);
    bus_a.req = 8'h08;
    tick();
    check("hold_gnt",   32'(bus_a.gnt), 32'h08);
    check("hold_id",    32'(bus_a.gnt_id), 32'd3);
    check("hold_start", 32'(bus_a.mem_start), 32'd1);
    bus_a.req   = 8'h00;
    bus_a.rr_en = 1'b1;
    seen = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      seen = seen & (bus_a.gnt == 8'h08);
    end
    check("hold_stable", 32'(seen), 32'd1);
    bus_a.mem_done = 1'b1;
    tick();
    bus_a.mem_done = 1'b0;
    check("hold_rel", 32'(bus_a.gnt), 32'h00);
    tick();
    check("hold_stay_idle", 32'(bus_a.gnt_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
